// File: rtl/e203_regfile_pkg.sv
// Shared constants and helpers for the multi-port EXU register file.
package e203_regfile_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned NUM_REGS_RV32I = 32;
    localparam int unsigned NUM_REGS_RV32E = 16;

    // Width of a register index for a file of num_regs entries.
    function automatic int unsigned reg_idx_w(input int unsigned num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/e203_regfile_scoreboard.sv
// Write-after-write scoreboard: per-register busy bits, allocation handshake and busy count.
module e203_regfile_scoreboard
    import e203_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_RV32I,
    localparam int unsigned AW      = reg_idx_w(NUM_REGS),
    localparam int unsigned CW      = reg_idx_w(NUM_REGS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_vld,
    input  logic [AW-1:0]       alloc_idx,
    input  logic [NUM_REGS-1:0] clr_vec,
    output logic [NUM_REGS-1:0] busy,
    output logic                alloc_rdy,
    output logic [CW-1:0]       busy_cnt
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    // Ready comes from registered state only; a same-cycle writeback does not unblock it.
    assign alloc_rdy = ~busy_q[alloc_idx];
    assign busy      = busy_q;
    assign busy_cnt  = cnt_q;

    // Next busy vector: clears first, then the allocation so a simultaneous set wins.
    always_comb begin
        busy_d = busy_q & ~clr_vec;
        if (alloc_vld && alloc_rdy && (alloc_idx != '0)) begin
            busy_d[alloc_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

    // Busy vector and its population count, synchronously reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/e203_exu_regfile_mp.sv
// Multi-port integer register file with optional write->read bypass and WAW scoreboard.
module e203_exu_regfile_mp
    import e203_regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned NUM_REGS = NUM_REGS_RV32I,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 2,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = reg_idx_w(NUM_REGS),
    localparam int unsigned CW      = reg_idx_w(NUM_REGS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NR*AW-1:0]   read_src_idx,
    output logic [NR*XLEN-1:0] read_src_dat,
    output logic [NR-1:0]      read_src_busy,
    input  logic [NW-1:0]      wbck_dest_wen,
    input  logic [NW*AW-1:0]   wbck_dest_idx,
    input  logic [NW*XLEN-1:0] wbck_dest_dat,
    input  logic               alloc_vld,
    input  logic [AW-1:0]      alloc_idx,
    output logic               alloc_rdy,
    output logic [CW-1:0]      busy_cnt,
    output logic [XLEN-1:0]    x1_r
);

    logic [XLEN-1:0]     rf [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] clr_vec;

    // Any writeback retires the outstanding allocation of its target register.
    always_comb begin
        clr_vec = '0;
        for (int w = 0; w < NW; w++) begin
            if (wbck_dest_wen[w]) begin
                clr_vec[wbck_dest_idx[w*AW +: AW]] = 1'b1;
            end
        end
    end

    // Register array; later write ports overwrite earlier ones, x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wbck_dest_wen[w] && (wbck_dest_idx[w*AW +: AW] != '0)) begin
                    rf[wbck_dest_idx[w*AW +: AW]] <= wbck_dest_dat[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Read ports with optional forwarding of same-cycle writebacks (highest port wins).
    always_comb begin
        read_src_dat  = '0;
        read_src_busy = '0;
        for (int i = 0; i < NR; i++) begin
            read_src_dat[i*XLEN +: XLEN] = rf[read_src_idx[i*AW +: AW]];
            read_src_busy[i]             = busy[read_src_idx[i*AW +: AW]];
            if (BYPASS) begin
                for (int w = 0; w < NW; w++) begin
                    if (wbck_dest_wen[w] &&
                        (wbck_dest_idx[w*AW +: AW] == read_src_idx[i*AW +: AW])) begin
                        read_src_busy[i] = 1'b0;
                        if (read_src_idx[i*AW +: AW] != '0) begin
                            read_src_dat[i*XLEN +: XLEN] = wbck_dest_dat[w*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    assign x1_r = rf[1];

    e203_regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx),
        .clr_vec   (clr_vec),
        .busy      (busy),
        .alloc_rdy (alloc_rdy),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// Bench: RV32I/bypass and RV32E/no-bypass instances driven together, checked against an array model.
module tb_e203_exu_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  rd_idx [2];
    logic [1:0]  wen;
    logic [4:0]  widx [2];
    logic [31:0] wdat [2];
    logic        alloc_vld;
    logic [4:0]  alloc_idx;

    logic [9:0]  a_ridx, a_widx;
    logic [7:0]  b_ridx, b_widx;
    logic [63:0] wdat_pk;
    logic [63:0] a_rdat, b_rdat;
    logic [1:0]  a_rbusy, b_rbusy;
    logic        a_rdy, b_rdy;
    logic [5:0]  a_cnt;
    logic [4:0]  b_cnt;
    logic [31:0] a_x1, b_x1;

    assign a_ridx  = {rd_idx[1], rd_idx[0]};
    assign b_ridx  = {rd_idx[1][3:0], rd_idx[0][3:0]};
    assign a_widx  = {widx[1], widx[0]};
    assign b_widx  = {widx[1][3:0], widx[0][3:0]};
    assign wdat_pk = {wdat[1], wdat[0]};

    e203_exu_regfile_mp #(
        .XLEN(32), .NUM_REGS(32), .NR(2), .NW(2), .BYPASS(1'b1)
    ) dut_a (
        .clk           (clk),
        .rst           (rst),
        .read_src_idx  (a_ridx),
        .read_src_dat  (a_rdat),
        .read_src_busy (a_rbusy),
        .wbck_dest_wen (wen),
        .wbck_dest_idx (a_widx),
        .wbck_dest_dat (wdat_pk),
        .alloc_vld     (alloc_vld),
        .alloc_idx     (alloc_idx),
        .alloc_rdy     (a_rdy),
        .busy_cnt      (a_cnt),
        .x1_r          (a_x1)
    );

    e203_exu_regfile_mp #(
        .XLEN(32), .NUM_REGS(16), .NR(2), .NW(2), .BYPASS(1'b0)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .read_src_idx  (b_ridx),
        .read_src_dat  (b_rdat),
        .read_src_busy (b_rbusy),
        .wbck_dest_wen (wen),
        .wbck_dest_idx (b_widx),
        .wbck_dest_dat (wdat_pk),
        .alloc_vld     (alloc_vld),
        .alloc_idx     (alloc_idx[3:0]),
        .alloc_rdy     (b_rdy),
        .busy_cnt      (b_cnt),
        .x1_r          (b_x1)
    );

    // Model: instance 0 = 32 regs with bypass, instance 1 = 16 regs without.
    logic [31:0] m_rf   [2][32];
    bit          m_busy [2][32];
    bit          model_on = 1'b0;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msk(input int k, input logic [4:0] idx);
        return (k == 0) ? int'(idx) : int'(idx[3:0]);
    endfunction

    function automatic logic [31:0] exp_dat(input int k, input int p);
        int r = msk(k, rd_idx[p]);
        logic [31:0] d = m_rf[k][r];
        if (k == 0) begin
            for (int w = 0; w < 2; w++) begin
                if (wen[w] && msk(k, widx[w]) == r && r != 0) d = wdat[w];
            end
        end
        return d;
    endfunction

    function automatic bit exp_busy(input int k, input int p);
        int r = msk(k, rd_idx[p]);
        bit b = m_busy[k][r];
        if (k == 0) begin
            for (int w = 0; w < 2; w++) begin
                if (wen[w] && msk(k, widx[w]) == r) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic int exp_cnt(input int k);
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[k][r]);
        return c;
    endfunction

    task automatic compare_model();
        if (!model_on) return;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_dat%0d", p), a_rdat[p*32 +: 32], exp_dat(0, p));
            chk($sformatf("b_dat%0d", p), b_rdat[p*32 +: 32], exp_dat(1, p));
            chk($sformatf("a_busy%0d", p), 32'(a_rbusy[p]), 32'(exp_busy(0, p)));
            chk($sformatf("b_busy%0d", p), 32'(b_rbusy[p]), 32'(exp_busy(1, p)));
        end
        chk("a_rdy", 32'(a_rdy), 32'(!m_busy[0][msk(0, alloc_idx)]));
        chk("b_rdy", 32'(b_rdy), 32'(!m_busy[1][msk(1, alloc_idx)]));
        chk("a_cnt", 32'(a_cnt), 32'(exp_cnt(0)));
        chk("b_cnt", 32'(b_cnt), 32'(exp_cnt(1)));
        chk("a_x1", a_x1, m_rf[0][1]);
        chk("b_x1", b_x1, m_rf[1][1]);
    endtask

    task automatic update_model();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    m_rf[k][r]   = '0;
                    m_busy[k][r] = 1'b0;
                end
            end else begin
                int  a   = msk(k, alloc_idx);
                bit  set = alloc_vld && !m_busy[k][a] && a != 0;
                for (int w = 0; w < 2; w++) begin
                    if (wen[w]) begin
                        int wi = msk(k, widx[w]);
                        if (wi != 0) m_rf[k][wi] = wdat[w];
                        m_busy[k][wi] = 1'b0;
                    end
                end
                if (set) m_busy[k][a] = 1'b1;
            end
        end
    endtask

    // Inputs are set just after a falling edge; outputs are compared before the rising edge.
    task automatic step();
        #1;
        compare_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; wen = '0; alloc_vld = 1'b0; alloc_idx = '0;
        for (int w = 0; w < 2; w++) begin
            widx[w] = '0;
            wdat[w] = '0;
        end
    endtask

    function automatic logic [4:0] rnd_idx();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_rf[k][r]   = '0;
                m_busy[k][r] = 1'b0;
            end
        end
        idle();
        rd_idx[0] = '0; rd_idx[1] = '0;
        rst = 1'b1;
        @(negedge clk);
        step();
        model_on = 1'b1;
        idle();

        // Reset state on every index.
        for (int r = 0; r < 32; r++) begin
            rd_idx[0] = 5'(r); rd_idx[1] = 5'(31 - r);
            #1;
            chk("rst_a_dat", a_rdat[31:0] | a_rdat[63:32], 32'h0);
            chk("rst_b_dat", b_rdat[31:0] | b_rdat[63:32], 32'h0);
            chk("rst_busy", 32'({a_rbusy, b_rbusy}), 32'h0);
        end
        @(negedge clk);
        #1;
        chk("rst_cnt", 32'(a_cnt) + 32'(b_cnt), 32'h0);
        chk("rst_x1", a_x1 | b_x1, 32'h0);
        chk("rst_rdy", 32'({a_rdy, b_rdy}), 32'h3);

        // Write x5 while reading it: bypass vs registered.
        wen = 2'b01; widx[0] = 5'd5; wdat[0] = 32'hDEAD_BEEF; rd_idx[0] = 5'd5;
        #1;
        chk("byp_a_x5", a_rdat[31:0], 32'hDEAD_BEEF);
        chk("nobyp_b_x5", b_rdat[31:0], 32'h0);
        step(); idle();
        #1;
        chk("next_b_x5", b_rdat[31:0], 32'hDEAD_BEEF);
        chk("next_a_x5", a_rdat[31:0], 32'hDEAD_BEEF);

        // Both ports write x7: port 1 wins; writes to x0 are dropped.
        wen = 2'b11; widx[0] = 5'd7; widx[1] = 5'd7; wdat[0] = 32'h11; wdat[1] = 32'h22;
        rd_idx[1] = 5'd7;
        #1;
        chk("byp_a_x7", a_rdat[63:32], 32'h22);
        step(); idle();
        #1;
        chk("a_x7", a_rdat[63:32], 32'h22);
        chk("b_x7", b_rdat[63:32], 32'h22);
        wen = 2'b01; widx[0] = 5'd0; wdat[0] = 32'hFFFF; rd_idx[0] = 5'd0;
        #1;
        chk("byp_a_x0", a_rdat[31:0], 32'h0);
        step(); idle();
        #1;
        chk("b_x0", b_rdat[31:0], 32'h0);

        // Allocate x3, stall a second alloc, release via writeback.
        alloc_vld = 1'b1; alloc_idx = 5'd3;
        #1;
        chk("alloc3_rdy", 32'(a_rdy), 32'h1);
        step(); idle();
        alloc_vld = 1'b1; alloc_idx = 5'd3;
        #1;
        chk("alloc3_cnt", 32'(a_cnt) + 32'(b_cnt), 32'h2);
        chk("alloc3_stall", 32'({a_rdy, b_rdy}), 32'h0);
        step(); idle();
        wen = 2'b01; widx[0] = 5'd3; wdat[0] = 32'h33; rd_idx[0] = 5'd3;
        #1;
        chk("wb3_a_busy_masked", 32'(a_rbusy[0]), 32'h0);
        chk("wb3_b_busy", 32'(b_rbusy[0]), 32'h1);
        step(); idle();
        alloc_idx = 5'd3;
        #1;
        chk("wb3_cnt", 32'(a_cnt), 32'h0);
        chk("wb3_rdy", 32'({a_rdy, b_rdy}), 32'h3);

        // Alloc and writeback of x4 together: set wins; then alloc x6 + wbck x4 nets zero.
        alloc_vld = 1'b1; alloc_idx = 5'd4; wen = 2'b01; widx[0] = 5'd4;
        step(); idle();
        alloc_idx = 5'd4;
        #1;
        chk("x4_cnt", 32'(a_cnt), 32'h1);
        chk("x4_busy_rdy", 32'({a_rdy, b_rdy}), 32'h0);
        alloc_vld = 1'b1; alloc_idx = 5'd6; wen = 2'b01; widx[0] = 5'd4;
        step(); idle();
        rd_idx[0] = 5'd6; rd_idx[1] = 5'd4;
        #1;
        chk("net0_cnt", 32'(a_cnt), 32'h1);
        chk("net0_a_busy", 32'(a_rbusy), 32'h1);
        chk("net0_b_busy", 32'(b_rbusy), 32'h1);

        // x1_r tracks x1 one cycle later; reset with three registers busy.
        wen = 2'b01; widx[0] = 5'd1; wdat[0] = 32'h1234;
        #1;
        chk("x1_before", b_x1, 32'h0);
        step(); idle();
        #1;
        chk("x1_b_after", b_x1, 32'h1234);
        chk("x1_a_after", a_x1, 32'h1234);
        alloc_vld = 1'b1; alloc_idx = 5'd8; wen = 2'b01; widx[0] = 5'd6;
        step(); idle();
        alloc_vld = 1'b1; alloc_idx = 5'd9;
        step(); idle();
        alloc_vld = 1'b1; alloc_idx = 5'd10;
        step(); idle();
        #1;
        chk("three_busy_b", 32'(b_cnt), 32'h3);
        rst = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd11;
        step(); idle();
        rd_idx[0] = 5'd8; rd_idx[1] = 5'd7;
        #1;
        chk("mid_rst_cnt", 32'(a_cnt) + 32'(b_cnt), 32'h0);
        chk("mid_rst_busy", 32'({a_rbusy, b_rbusy}), 32'h0);
        chk("mid_rst_x1", a_x1 | b_x1, 32'h0);
        chk("mid_rst_x7", a_rdat[63:32] | b_rdat[63:32], 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            wen       = 2'($urandom_range(0, 3));
            alloc_vld = 1'($urandom_range(0, 1));
            alloc_idx = rnd_idx();
            for (int w = 0; w < 2; w++) begin
                widx[w] = rnd_idx();
                wdat[w] = $urandom;
            end
            rd_idx[0] = rnd_idx();
            rd_idx[1] = rnd_idx();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
